// File: rtl/spi_bridge.sv
// rtl/spi_bridge.sv - SPI mode-0 slave bridging serial frames to byte-wide transfers (option: SPI_LSB_FIRST_EN)
module spi_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       byte_sync,
    output logic [7:0] data_in,
    input  logic [7:0] data_out
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;

    logic [0:0] state;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [2:0] bit_cnt;
    logic       tx_reload;
    logic       rx_done;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;

    // cs_n chain resets low so a select already held across reset never looks like a fresh fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rx_shift  <= 8'h00;
            tx_shift  <= 8'h00;
            bit_cnt   <= 3'd0;
            tx_reload <= 1'b0;
            rx_done   <= 1'b0;
            miso      <= 1'b0;
            byte_sync <= 1'b0;
            data_in   <= 8'h00;
        end else begin
            byte_sync <= 1'b0;
            rx_done   <= 1'b0;
            if (rx_done) begin
                data_in   <= rx_shift;
                byte_sync <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state     <= ST_ACTIVE;
                        tx_shift  <= data_out;
                        bit_cnt   <= 3'd0;
                        tx_reload <= 1'b0;
                    end
                end
                default: begin
                    if (cs_s) begin
                        // deselect outranks any coincident sclk edge
                        state     <= ST_IDLE;
                        bit_cnt   <= 3'd0;
                        tx_reload <= 1'b0;
                        miso      <= 1'b0;
                    end else begin
`ifdef SPI_LSB_FIRST_EN
                        miso <= tx_shift[0];
`else
                        miso <= tx_shift[7];
`endif
                        if (sclk_rise) begin
`ifdef SPI_LSB_FIRST_EN
                            rx_shift <= {mosi_s, rx_shift[7:1]};
`else
                            rx_shift <= {rx_shift[6:0], mosi_s};
`endif
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_done   <= 1'b1;
                                tx_reload <= 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            if (tx_reload) begin
                                tx_shift  <= data_out;
                                tx_reload <= 1'b0;
                            end else begin
`ifdef SPI_LSB_FIRST_EN
                                tx_shift <= {1'b0, tx_shift[7:1]};
`else
                                tx_shift <= {tx_shift[6:0], 1'b0};
`endif
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
